execute_stage_hs: RTL and testbench

- Parametrised successor of the single-cycle execute stage. Adds a valid/ready handshake on both sides, generic N-source operand forwarding, flush support and an iterative multi-cycle multiplier mode.
- Sits between the ID/EX register and the memory stage.
- Resolves branches and jumps. Emits a registered redirect pulse on misprediction.
- Holds its EX/MEM output register under downstream back-pressure.

---
 rtl/execute_stage_hs_if.sv | 53 +++++
 rtl/execute_stage_hs.sv | 215 +++++++++++++++++++++
 tb/tb_execute_stage_hs.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_hs_if.sv
// Handshake and datapath bundle between the ID/EX register, the execute stage and the memory stage.
// slave = the execute stage itself, master = whatever drives it (decode side plus memory-stage ready).
interface execute_stage_hs_if #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int CTRL_W  = 12
);
   localparam int SEL_W = $clog2(NUM_FWD + 1);

   logic                    in_valid_i;
   logic                    in_ready_o;
   logic                    flush_i;
   logic [XLEN-1:0]         op_a_i;
   logic [XLEN-1:0]         op_b_i;
   logic [XLEN-1:0]         store_data_i;
   logic [XLEN-1:0]         pc_i;
   logic [XLEN-1:0]         imm_i;
   logic [3:0]              alu_op_i;
   logic [2:0]              br_op_i;
   logic                    pred_taken_i;
   logic [XLEN-1:0]         pred_target_i;
   logic [SEL_W-1:0]        a_sel_i;
   logic [SEL_W-1:0]        b_sel_i;
   logic [SEL_W-1:0]        s_sel_i;
   logic [NUM_FWD*XLEN-1:0] fwd_data_i;
   logic [CTRL_W-1:0]       ctrl_i;

   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [XLEN-1:0]         result_o;
   logic [XLEN-1:0]         store_data_o;
   logic [CTRL_W-1:0]       ctrl_o;
   logic                    redirect_o;
   logic [XLEN-1:0]         redirect_pc_o;
   logic                    bp_update_o;
   logic                    bp_taken_o;

   modport slave (
      input  in_valid_i, flush_i, op_a_i, op_b_i, store_data_i, pc_i, imm_i,
             alu_op_i, br_op_i, pred_taken_i, pred_target_i,
             a_sel_i, b_sel_i, s_sel_i, fwd_data_i, ctrl_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, store_data_o, ctrl_o,
             redirect_o, redirect_pc_o, bp_update_o, bp_taken_o
   );

   modport master (
      output in_valid_i, flush_i, op_a_i, op_b_i, store_data_i, pc_i, imm_i,
             alu_op_i, br_op_i, pred_taken_i, pred_target_i,
             a_sel_i, b_sel_i, s_sel_i, fwd_data_i, ctrl_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, store_data_o, ctrl_o,
             redirect_o, redirect_pc_o, bp_update_o, bp_taken_o
   );
endinterface

// File: rtl/execute_stage_hs.sv
// Execute stage with valid/ready handshake, N-source operand forwarding, flush,
// branch resolution and an iterative shift-add multiplier.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accepting instructions; non-MUL ops complete in one cycle
// BUSY   | shift-add multiply, one multiplier bit per cycle, XLEN cycles
// DONE   | product ready, waiting for the output register to be free
module execute_stage_hs #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int MUL_EN  = 1,
   parameter int CTRL_W  = 12
) (
   input  logic             clk,
   input  logic             reset,
   execute_stage_hs_if.slave bus
);
   localparam int  SEL_W  = $clog2(NUM_FWD + 1);
   localparam int  SH_W   = $clog2(XLEN);
   localparam int  CNT_W  = $clog2(XLEN);
   localparam bit  MUL_ON = (MUL_EN != 0);

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                          OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_PASSB = 4'd10, OP_MUL = 4'd11;

   localparam logic [2:0] BR_JAL = 3'd1, BR_JALR = 3'd2, BR_BEQ = 3'd3, BR_BNE = 3'd4,
                          BR_BLT = 3'd5, BR_BGE = 3'd6, BR_BLTU = 3'd7;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t state, state_nxt;

   logic              out_valid_q;
   logic [XLEN-1:0]   result_q, store_data_q, redirect_pc_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              redirect_q, bp_update_q, bp_taken_q;

   logic [XLEN-1:0]   mcand_q, mplier_q, acc_q, mul_sd_q;
   logic [CTRL_W-1:0] mul_ctrl_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              out_free, in_ready, accept, is_mul;
   logic              mul_step, mul_load;

   // Select index 0 or anything above NUM_FWD falls back to the decoded operand.
   function automatic logic [XLEN-1:0] fwd_mux(
      input logic [SEL_W-1:0]        sel,
      input logic [XLEN-1:0]         own,
      input logic [NUM_FWD*XLEN-1:0] fwd
   );
      logic [XLEN-1:0] r;
      r = own;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (int'(sel) == k) r = fwd[(k-1)*XLEN +: XLEN];
      end
      return r;
   endfunction

   logic [XLEN-1:0] a_mux, b_mux, s_mux;

   always_comb begin
      a_mux = fwd_mux(bus.a_sel_i, bus.op_a_i, bus.fwd_data_i);
      b_mux = fwd_mux(bus.b_sel_i, bus.op_b_i, bus.fwd_data_i);
      s_mux = fwd_mux(bus.s_sel_i, bus.store_data_i, bus.fwd_data_i);
   end

   logic [SH_W-1:0] sh_amt;
   logic [XLEN-1:0] alu_res;

   always_comb begin
      sh_amt = b_mux[SH_W-1:0];
      case (bus.alu_op_i)
         OP_SUB:   alu_res = a_mux - b_mux;
         OP_AND:   alu_res = a_mux & b_mux;
         OP_OR:    alu_res = a_mux | b_mux;
         OP_XOR:   alu_res = a_mux ^ b_mux;
         OP_SLL:   alu_res = a_mux << sh_amt;
         OP_SRL:   alu_res = a_mux >> sh_amt;
         OP_SRA:   alu_res = $signed(a_mux) >>> sh_amt;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(a_mux) < $signed(b_mux)};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, a_mux < b_mux};
         OP_PASSB: alu_res = b_mux;
         default:  alu_res = a_mux + b_mux;
      endcase
   end

   logic [XLEN-1:0] pc_plus4, br_target, ex_result;
   logic            taken, mispredict, cond_br, is_jump;

   always_comb begin
      pc_plus4  = bus.pc_i + XLEN'(4);
      br_target = (bus.br_op_i == BR_JALR) ? ((a_mux + bus.imm_i) & {{(XLEN-1){1'b1}}, 1'b0})
                                           : (bus.pc_i + bus.imm_i);
      case (bus.br_op_i)
         BR_JAL, BR_JALR: taken = 1'b1;
         BR_BEQ:          taken = (a_mux == b_mux);
         BR_BNE:          taken = (a_mux != b_mux);
         BR_BLT:          taken = ($signed(a_mux) <  $signed(b_mux));
         BR_BGE:          taken = ($signed(a_mux) >= $signed(b_mux));
         BR_BLTU:         taken = bus.alu_op_i[0] ? (a_mux >= b_mux) : (a_mux < b_mux);
         default:         taken = 1'b0;
      endcase
      mispredict = (taken != bus.pred_taken_i) | (taken & (br_target != bus.pred_target_i));
      cond_br    = (bus.br_op_i >= BR_BEQ);
      is_jump    = (bus.br_op_i == BR_JAL) | (bus.br_op_i == BR_JALR);
      ex_result  = is_jump ? pc_plus4 : alu_res;
   end

   always_comb begin
      out_free = ~out_valid_q | bus.out_ready_i;
      is_mul   = MUL_ON & (bus.alu_op_i == OP_MUL);
      accept   = bus.in_valid_i & in_ready & ~bus.flush_i;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept && is_mul) state_nxt = S_BUSY;
            S_BUSY:  if (cnt_q == '0)      state_nxt = S_DONE;
            S_DONE:  if (out_free)         state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == S_IDLE) & out_free;
      mul_step = (state == S_BUSY);
      mul_load = (state == S_DONE) & out_free & ~bus.flush_i;
   end

   // Operands, store data and control are captured at accept so the ID side may move on.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         mul_sd_q   <= '0;
         mul_ctrl_q <= '0;
         cnt_q      <= '0;
      end else if (accept && is_mul) begin
         mcand_q    <= a_mux;
         mplier_q   <= b_mux;
         acc_q      <= '0;
         mul_sd_q   <= s_mux;
         mul_ctrl_q <= bus.ctrl_i;
         cnt_q      <= CNT_W'(XLEN - 1);
      end else if (mul_step) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         store_data_q <= '0;
         ctrl_q       <= '0;
      end else if (bus.flush_i) begin
         out_valid_q  <= 1'b0;
      end else if (accept && !is_mul) begin
         out_valid_q  <= 1'b1;
         result_q     <= ex_result;
         store_data_q <= s_mux;
         ctrl_q       <= bus.ctrl_i;
      end else if (mul_load) begin
         out_valid_q  <= 1'b1;
         result_q     <= acc_q;
         store_data_q <= mul_sd_q;
         ctrl_q       <= mul_ctrl_q;
      end else if (bus.out_ready_i) begin
         out_valid_q  <= 1'b0;
      end
   end

   // Pulses follow accept only, so stalls never stretch them and flush suppresses them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect_q    <= 1'b0;
         bp_update_q   <= 1'b0;
         bp_taken_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         redirect_q  <= accept & mispredict;
         bp_update_q <= accept & cond_br;
         if (accept) begin
            redirect_pc_q <= taken ? br_target : pc_plus4;
            bp_taken_q    <= taken & cond_br;
         end
      end
   end

   assign bus.in_ready_o    = in_ready;
   assign bus.out_valid_o   = out_valid_q;
   assign bus.result_o      = result_q;
   assign bus.store_data_o  = store_data_q;
   assign bus.ctrl_o        = ctrl_q;
   assign bus.redirect_o    = redirect_q;
   assign bus.redirect_pc_o = redirect_pc_q;
   assign bus.bp_update_o   = bp_update_q;
   assign bus.bp_taken_o    = bp_taken_q;
endmodule

// File: tb/tb_execute_stage_hs.sv
// Scoreboard bench for execute_stage_hs: directed vectors push expected beats,
// a negedge monitor pops and compares output beats and branch pulses.
module tb_execute_stage_hs;
   localparam int XLEN = 32, NUM_FWD = 2, CTRL_W = 12;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   execute_stage_hs_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W)) bus ();

   execute_stage_hs #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .MUL_EN(1), .CTRL_W(CTRL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {logic [31:0] res; logic [31:0] sd; logic [11:0] ctrl;} out_t;
   typedef struct packed {logic redir; logic [31:0] pc; logic upd; logic tk;} br_t;

   out_t exp_q[$];
   br_t  br_q[$];
   out_t mon_o;
   br_t  mon_b;
   int   checks = 0;
   int   errors = 0;
   int   stall_waits = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic push_out(input logic [31:0] res, input logic [31:0] sd, input logic [11:0] ctrl);
      out_t t;
      t.res = res; t.sd = sd; t.ctrl = ctrl;
      exp_q.push_back(t);
   endtask

   task automatic push_br(input logic redir, input logic [31:0] pc, input logic upd, input logic tk);
      br_t t;
      t.redir = redir; t.pc = pc; t.upd = upd; t.tk = tk;
      br_q.push_back(t);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out actual=0x%08h required=none", bus.result_o);
            end else begin
               mon_o = exp_q.pop_front();
               check("result", bus.result_o, mon_o.res);
               check("store_data", bus.store_data_o, mon_o.sd);
               check("ctrl", {20'h0, bus.ctrl_o}, {20'h0, mon_o.ctrl});
            end
         end
         if (bus.redirect_o || bus.bp_update_o) begin
            if (br_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_pulse actual=redir%0d/upd%0d required=none",
                        bus.redirect_o, bus.bp_update_o);
            end else begin
               mon_b = br_q.pop_front();
               check("redirect", {31'h0, bus.redirect_o}, {31'h0, mon_b.redir});
               check("redirect_pc", bus.redirect_pc_o, mon_b.pc);
               check("bp_update", {31'h0, bus.bp_update_o}, {31'h0, mon_b.upd});
               if (mon_b.upd) check("bp_taken", {31'h0, bus.bp_taken_o}, {31'h0, mon_b.tk});
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [2:0] br,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt,
                        input logic [1:0] asel, input logic [1:0] bsel, input logic [1:0] ssel,
                        input logic [11:0] ctrl);
      int n;
      bus.alu_op_i = op; bus.br_op_i = br; bus.op_a_i = a; bus.op_b_i = b;
      bus.store_data_i = sd; bus.pc_i = pc; bus.imm_i = imm;
      bus.pred_taken_i = pt; bus.pred_target_i = ptgt;
      bus.a_sel_i = asel; bus.b_sel_i = bsel; bus.s_sel_i = ssel; bus.ctrl_i = ctrl;
      bus.in_valid_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      stall_waits += n;
      if (!bus.in_ready_o) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
      end
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
   endtask

   logic [3:0]  t_op  [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15, 4'd0};
   logic [31:0] t_a   [13] = '{32'd5, 32'd10, 32'hF0, 32'hF0, 32'hFF, 32'd1, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'hFFFF_FFFF};
   logic [31:0] t_b   [13] = '{32'd7, 32'd3, 32'h3C, 32'h0F, 32'h0F, 32'h24, 32'd4, 32'd4,
                               32'd1, 32'd1, 32'h1234, 32'd3, 32'd2};
   logic [31:0] t_exp [13] = '{32'd12, 32'd7, 32'h30, 32'hFF, 32'hF0, 32'h10, 32'h0800_0000, 32'hF800_0000,
                               32'd1, 32'd0, 32'h1234, 32'd5, 32'd1};

   initial begin
      logic [11:0] ctl;
      int n;
      bus.in_valid_i = 0; bus.flush_i = 0; bus.op_a_i = 0; bus.op_b_i = 0; bus.store_data_i = 0;
      bus.pc_i = 0; bus.imm_i = 0; bus.alu_op_i = 0; bus.br_op_i = 0; bus.pred_taken_i = 0;
      bus.pred_target_i = 0; bus.a_sel_i = 0; bus.b_sel_i = 0; bus.s_sel_i = 0;
      bus.fwd_data_i = 0; bus.ctrl_i = 0; bus.out_ready_i = 1;

      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
      check("rst_result", bus.result_o, 32'h0);
      check("rst_store_data", bus.store_data_o, 32'h0);
      check("rst_ctrl", {20'h0, bus.ctrl_o}, 32'h0);
      check("rst_redirect", {31'h0, bus.redirect_o}, 32'h0);
      check("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
      check("rst_bp_update", {31'h0, bus.bp_update_o}, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
      @(posedge clk); #1;

      // ALU table, issued back to back
      stall_waits = 0;
      for (int i = 0; i < 13; i++) begin
         ctl = 12'(12'h5A5 + i);
         push_out(t_exp[i], {20'h0, ctl}, ctl);
         issue(t_op[i], 3'd0, t_a[i], t_b[i], {20'h0, ctl}, 32'h0, 32'h0, 1'b0, 32'h0, 2'd0, 2'd0, 2'd0, ctl);
      end
      check("back_to_back_stalls", stall_waits, 32'd0);

      // forwarding
      bus.fwd_data_i = {32'h0000_0100, 32'h0000_AAAA};
      push_out(32'hFF, 32'h11, 12'h001);
      issue(4'd1, 3'd0, 32'h5, 32'h1, 32'h11, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 12'h001);
      push_out(32'h21, 32'h12, 12'h002);
      issue(4'd0, 3'd0, 32'h20, 32'h1, 32'h12, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 12'h002);
      push_out(32'hAAAB, 32'h13, 12'h003);
      issue(4'd0, 3'd0, 32'h1, 32'h9, 32'h13, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 12'h003);
      push_out(32'h3, 32'h100, 12'h004);
      issue(4'd0, 3'd0, 32'h1, 32'h2, 32'h14, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 12'h004);

      // multiply latency and result
      push_out(32'hFFFF_FFFD, 32'h77, 12'h0AB);
      issue(4'd11, 3'd0, 32'hFFFF_FFFF, 32'h3, 32'h77, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 12'h0AB);
      n = 0;
      @(negedge clk);
      while (!bus.in_ready_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("mul_busy_cycles", n, 32'd33);
      check("mul_valid_rise", {31'h0, bus.out_valid_o}, 32'h1);
      @(posedge clk); #1;

      // multiply with forwarded operand, forward bus changes after accept
      push_out(32'h0001_5554, 32'h100, 12'h0AC);
      issue(4'd11, 3'd0, 32'h0, 32'h2, 32'h5, 0, 0, 0, 0, 2'd1, 2'd0, 2'd2, 12'h0AC);
      bus.fwd_data_i = '0;
      repeat (40) @(negedge clk);
      @(posedge clk); #1;

      // multiply flushed at cycle 10
      issue(4'd11, 3'd0, 32'd7, 32'd6, 32'h0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 12'h0AD);
      repeat (9) @(posedge clk);
      #1 bus.flush_i = 1'b1;
      @(posedge clk); #1 bus.flush_i = 1'b0;
      @(negedge clk);
      check("flush_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
      check("flush_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
      repeat (40) @(negedge clk);
      check("flush_no_output", {31'h0, bus.out_valid_o}, 32'h0);
      @(posedge clk); #1;

      // branches
      push_out(32'd10, 0, 12'h010); push_br(1, 32'h90, 1, 1);
      issue(4'd0, 3'd3, 32'd5, 32'd5, 0, 32'h80, 32'h10, 1'b0, 32'h0, 0, 0, 0, 12'h010);
      push_out(32'd10, 0, 12'h011); push_br(0, 32'h90, 1, 1);
      issue(4'd0, 3'd3, 32'd5, 32'd5, 0, 32'h80, 32'h10, 1'b1, 32'h90, 0, 0, 0, 12'h011);
      push_out(32'd10, 0, 12'h012); push_br(0, 32'h84, 1, 0);
      issue(4'd0, 3'd4, 32'd5, 32'd5, 0, 32'h80, 32'h10, 1'b0, 32'h0, 0, 0, 0, 12'h012);
      push_out(32'd0, 0, 12'h013); push_br(1, 32'h120, 1, 1);
      issue(4'd0, 3'd5, 32'hFFFF_FFFF, 32'd1, 0, 32'h100, 32'h20, 1'b0, 32'h0, 0, 0, 0, 12'h013);
      push_out(32'd0, 0, 12'h014); push_br(1, 32'h104, 1, 0);
      issue(4'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 0, 32'h100, 32'h20, 1'b1, 32'h120, 0, 0, 0, 12'h014);
      push_out(32'd2, 0, 12'h015); push_br(1, 32'h44, 1, 0);
      issue(4'd1, 3'd7, 32'd1, 32'hFFFF_FFFF, 0, 32'h40, 32'h8, 1'b1, 32'h48, 0, 0, 0, 12'h015);
      push_out(32'd0, 0, 12'h016); push_br(0, 32'h48, 1, 1);
      issue(4'd0, 3'd7, 32'd1, 32'hFFFF_FFFF, 0, 32'h40, 32'h8, 1'b1, 32'h48, 0, 0, 0, 12'h016);
      push_out(32'h204, 0, 12'h017); push_br(1, 32'h1002, 0, 0);
      issue(4'd0, 3'd2, 32'h1003, 32'h0, 0, 32'h200, 32'h0, 1'b0, 32'h0, 0, 0, 0, 12'h017);
      push_out(32'h0, 0, 12'h018);
      issue(4'd0, 3'd1, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4, 0, 0, 0, 12'h018);
      push_out(32'h14, 0, 12'h019); push_br(1, 32'h50, 0, 0);
      issue(4'd0, 3'd1, 32'h0, 32'h0, 0, 32'h10, 32'h40, 1'b1, 32'h44, 0, 0, 0, 12'h019);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;

      // flush in the same cycle as a mispredicted branch: nothing may come out
      bus.alu_op_i = 0; bus.br_op_i = 3'd3; bus.op_a_i = 5; bus.op_b_i = 5; bus.pc_i = 32'h80;
      bus.imm_i = 32'h10; bus.pred_taken_i = 0; bus.a_sel_i = 0; bus.b_sel_i = 0; bus.s_sel_i = 0;
      bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
      @(posedge clk); #1 bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
      @(negedge clk);
      check("flush_redirect", {31'h0, bus.redirect_o}, 32'h0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;

      // flush kills a stalled output
      bus.out_ready_i = 1'b0;
      issue(4'd0, 3'd0, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0, 12'h020);
      @(negedge clk);
      check("stall_flush_pre", {31'h0, bus.out_valid_o}, 32'h1);
      @(posedge clk); #1 bus.flush_i = 1'b1;
      @(posedge clk); #1 bus.flush_i = 1'b0;
      @(negedge clk);
      check("stall_flush_post", {31'h0, bus.out_valid_o}, 32'h0);
      @(posedge clk); #1;

      // stall holds the output, then async reset mid-stall
      issue(4'd0, 3'd0, 32'd100, 32'd1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 12'h123);
      @(negedge clk);
      check("stall_valid", {31'h0, bus.out_valid_o}, 32'h1);
      check("stall_result", bus.result_o, 32'd101);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_hold_result", bus.result_o, 32'd101);
         check("stall_hold_ctrl", {20'h0, bus.ctrl_o}, 32'h123);
         check("stall_in_ready", {31'h0, bus.in_ready_o}, 32'h0);
      end
      @(posedge clk); #2 reset = 1'b0;
      #1;
      check("async_rst_valid", {31'h0, bus.out_valid_o}, 32'h0);
      check("async_rst_result", bus.result_o, 32'h0);
      check("async_rst_store", bus.store_data_o, 32'h0);
      check("async_rst_ctrl", {20'h0, bus.ctrl_o}, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      bus.out_ready_i = 1'b1;

      push_out(32'd4, 32'h9, 12'h030);
      issue(4'd0, 3'd0, 32'd2, 32'd2, 32'h9, 0, 0, 0, 0, 0, 0, 0, 12'h030);
      repeat (5) @(negedge clk);
      check("out_queue_empty", exp_q.size(), 32'd0);
      check("br_queue_empty", br_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
